// File: rtl/divider_control.sv
// rtl/divider_control.sv - sequencer for the 32-bit shift/subtract divider datapath
// Moore FSM driving remainder-register strobes and ALU select through one division.
module divider_control #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic             Divisor_zero,
    output logic             W_ctrl,
    output logic             SLL_ctrl,
    output logic             SRL_ctrl,
    output logic             ALU_sub,
    output logic             Busy,
    output logic             Ready,
    output logic             Done,
    output logic             Dz_err,
    output logic [CNT_W-1:0] Iter_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dz_nxt;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            Iter_cnt <= '0;
            Dz_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            Iter_cnt <= cnt_nxt;
            Dz_err   <= dz_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = Iter_cnt;
        dz_nxt    = Dz_err;
        W_ctrl    = 1'b0;
        SLL_ctrl  = 1'b0;
        SRL_ctrl  = 1'b0;
        ALU_sub   = 1'b0;
        Busy      = 1'b0;
        Ready     = 1'b0;
        Done      = 1'b0;
        case (state)
            S_IDLE: begin
                Ready = 1'b1;
                if (start) begin
                    // A zero divisor skips the datapath entirely and reports via Dz_err.
                    dz_nxt    = Divisor_zero;
                    state_nxt = Divisor_zero ? S_DONE : S_INIT;
                end
            end
            S_INIT: begin
                Busy      = 1'b1;
                W_ctrl    = 1'b1;
                cnt_nxt   = CNT_W'(ITER - 1);
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                Busy     = 1'b1;
                SLL_ctrl = 1'b1;
                ALU_sub  = 1'b1;
                if (Iter_cnt != '0) begin
                    cnt_nxt = Iter_cnt - CNT_W'(1);
                end else begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                Busy      = 1'b1;
                SRL_ctrl  = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                Done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_divider_control.sv
// tb/tb_divider_control.sv - self-checking bench for divider_control
// Timeline model of one division plus a remainder-register/ALU model for closed-loop results.
module tb_divider_control;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    logic             clk = 1'b0;
    logic             Reset;
    logic             start;
    logic             Divisor_zero;
    logic             W_ctrl, SLL_ctrl, SRL_ctrl, ALU_sub;
    logic             Busy, Ready, Done, Dz_err;
    logic [CNT_W-1:0] Iter_cnt;

    divider_control #(.ITER(ITER), .CNT_W(CNT_W)) dut (
        .clk(clk), .Reset(Reset), .start(start), .Divisor_zero(Divisor_zero),
        .W_ctrl(W_ctrl), .SLL_ctrl(SLL_ctrl), .SRL_ctrl(SRL_ctrl), .ALU_sub(ALU_sub),
        .Busy(Busy), .Ready(Ready), .Done(Done), .Dz_err(Dz_err), .Iter_cnt(Iter_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle", nm, act, exp);
        end
    endtask

    // Abstract model: an accepted request at edge t0 defines every output by cycle offset.
    int   cyc     = 0;
    int   m_t0    = 0;
    logic m_valid = 1'b0;
    logic m_act   = 1'b0;
    logic m_dz    = 1'b0;
    logic m_dzerr = 1'b0;

    always @(posedge clk) begin
        if (Reset) begin
            m_valid = 1'b1;
            m_act   = 1'b0;
            m_dzerr = 1'b0;
        end else if (!m_act) begin
            if (start) begin
                m_act   = 1'b1;
                m_dz    = Divisor_zero;
                m_dzerr = Divisor_zero;
                m_t0    = cyc;
            end
        end else if (cyc - m_t0 == (m_dz ? 1 : ITER + 3)) begin
            m_act = 1'b0;
        end
        cyc = cyc + 1;
    end

    // Datapath model and per-operation observation counters
    logic [31:0] dividend, divisor;
    logic [64:0] rem_reg;
    logic [32:0] hi;
    logic [31:0] q_res, r_res;
    int base;
    int n_w, n_sll, n_srl, n_done;
    int sll_first, sll_last, srl_cyc, done_cyc, ready_cyc, w_last;

    always @(negedge clk) begin
        int  k;
        int  ci;
        logic e_sll;
        if (m_valid) begin
            k     = cyc - m_t0;
            e_sll = m_act && !m_dz && k >= 2 && k <= ITER + 1;
            chk("Ready", Ready, !m_act);
            chk("Busy", Busy, m_act && !m_dz && k <= ITER + 2);
            chk("W_ctrl", W_ctrl, m_act && !m_dz && k == 1);
            chk("SLL_ctrl", SLL_ctrl, e_sll);
            chk("ALU_sub", ALU_sub, e_sll);
            chk("SRL_ctrl", SRL_ctrl, m_act && !m_dz && k == ITER + 2);
            chk("Done", Done, m_act && (m_dz ? k == 1 : k == ITER + 3));
            chk("Dz_err", Dz_err, m_dzerr);
            chk("Iter_cnt", Iter_cnt, e_sll ? 64'(ITER + 1 - k) : 64'd0);

            ci = cyc - base;
            if (W_ctrl) begin
                n_w++;
                w_last = ci;
            end
            if (SLL_ctrl) begin
                if (n_sll == 0) sll_first = ci;
                n_sll++;
                sll_last = ci;
            end
            if (SRL_ctrl) begin
                n_srl++;
                srl_cyc = ci;
            end
            if (Done) begin
                if (n_done == 0) begin
                    done_cyc = ci;
                    q_res    = rem_reg[31:0];
                    r_res    = rem_reg[63:32];
                end
                n_done++;
            end
            if (n_done != 0 && Ready && ready_cyc == 0) ready_cyc = ci;

            // Restoring division, remainder register loaded pre-shifted by one
            if (W_ctrl) rem_reg = {32'd0, dividend, 1'b0};
            if (SLL_ctrl) begin
                hi = rem_reg[64:32];
                if (hi >= {1'b0, divisor}) begin
                    rem_reg[64:32] = hi - {1'b0, divisor};
                    rem_reg        = {rem_reg[63:0], 1'b1};
                end else begin
                    rem_reg = {rem_reg[63:0], 1'b0};
                end
            end
            if (SRL_ctrl) rem_reg[64:32] = rem_reg[64:32] >> 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        n_w = 0; n_sll = 0; n_srl = 0; n_done = 0;
        sll_first = 0; sll_last = 0; srl_cyc = 0; done_cyc = 0; ready_cyc = 0; w_last = 0;
        q_res = '0; r_res = '0;
    endtask

    // Presents start for 'hold' edges and waits for 'dones' completions plus one IDLE cycle.
    task automatic do_op(input logic [31:0] dvd, input logic [31:0] dvs, input logic dz,
                         input int hold, input int dones);
        int i;
        dividend = dvd; divisor = dvs; Divisor_zero = dz; start = 1'b1;
        clear_obs();
        tick();
        base = cyc - 1;
        for (i = 1; i < hold; i++) tick();
        start = 1'b0; Divisor_zero = 1'b0;
        for (i = 0; i < 200 && n_done < dones; i++) tick();
        chk("done_timeout", n_done, dones);
        tick();
        tick();
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; Divisor_zero = 1'b0;
        dividend = '0; divisor = '0; rem_reg = '0; base = 0;
        clear_obs();
        tick(); tick();
        Reset = 1'b0;
        chk("rst_ready", Ready, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_dz", Dz_err, 1'b0);
        chk("rst_strobes", {W_ctrl, SLL_ctrl, SRL_ctrl, ALU_sub}, 4'b0000);
        tick(); tick();

        do_op(32'd100, 32'd7, 1'b0, 1, 1);
        chk("n_w", n_w, 1);
        chk("w_cycle", w_last, 1);
        chk("n_sll", n_sll, 32);
        chk("sll_first", sll_first, 2);
        chk("sll_last", sll_last, 33);
        chk("n_srl", n_srl, 1);
        chk("srl_cycle", srl_cyc, 34);
        chk("done_cycle", done_cyc, 35);
        chk("ready_cycle", ready_cyc, 36);
        chk("q_100_7", q_res, 32'd14);
        chk("r_100_7", r_res, 32'd2);

        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1, 1);
        chk("q_max_1", q_res, 32'hFFFF_FFFF);
        chk("r_max_1", r_res, 32'd0);

        do_op(32'd1234, 32'd0, 1'b1, 1, 1);
        chk("dz_done_cycle", done_cyc, 1);
        chk("dz_strobes", n_w + n_sll + n_srl, 0);
        chk("dz_flag", Dz_err, 1'b1);
        tick();
        chk("dz_sticky", Dz_err, 1'b1);

        dividend = 32'd1000; divisor = 32'd33; start = 1'b1;
        clear_obs();
        tick();
        base = cyc - 1;
        start = 1'b0;
        chk("dz_clear_init", Dz_err, 1'b0);
        chk("dz_clear_w", W_ctrl, 1'b1);
        for (int i = 0; i < 200 && n_done < 1; i++) tick();
        chk("done_timeout", n_done, 1);
        chk("q_1000_33", q_res, 32'd30);
        chk("r_1000_33", r_res, 32'd10);
        tick(); tick();

        do_op(32'd50, 32'd5, 1'b0, 40, 2);
        chk("busy_done_cycle", done_cyc, 35);
        chk("busy_n_w", n_w, 2);
        chk("busy_second_init", w_last, 37);
        chk("q_50_5", q_res, 32'd10);

        dividend = 32'd999; divisor = 32'd3; start = 1'b1;
        clear_obs();
        tick();
        base = cyc - 1;
        start = 1'b0;
        for (int i = 1; i < 16; i++) tick();
        chk("mid_cnt17", Iter_cnt, 6'd17);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_ready", Ready, 1'b1);
        chk("mid_cnt0", Iter_cnt, 6'd0);
        for (int i = 0; i < 40; i++) tick();
        chk("mid_no_srl", n_srl, 0);
        chk("mid_no_done", n_done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
